// File: rtl/simple_reg_chk.sv
// Response checker for the simple register datapath: predicts each output from the
// input seen LAT edges earlier, compares N_CHECK samples and records the first failure.
module simple_reg_chk #(
    parameter int W0      = 9,
    parameter int W1      = 32,
    parameter int LAT     = 1,
    parameter int N_CHECK = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W0-1:0] d_in_0,
    input  logic [W1-1:0] d_in_1,
    input  logic [W0-1:0] d_out_0,
    input  logic [W1-1:0] d_out_1,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    match_cnt,
    output logic [7:0]    err_cnt,
    output logic [7:0]    first_err_idx,
    output logic [1:0]    first_err_mask
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_CHECK,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    flush_q, flush_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    match_q, match_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    fidx_q, fidx_d;
    logic [1:0]    fmask_q, fmask_d;
    logic [W0-1:0] exp0_q [LAT];
    logic [W1-1:0] exp1_q [LAT];
    logic          m0, m1;

    // Expected pipelines run in every state so FLUSH only has to wait, never preload
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                exp0_q[i] <= '0;
                exp1_q[i] <= '0;
            end
        end else begin
            exp0_q[0] <= d_in_0;
            exp1_q[0] <= d_in_1;
            for (int unsigned i = 1; i < LAT; i++) begin
                exp0_q[i] <= exp0_q[i-1];
                exp1_q[i] <= exp1_q[i-1];
            end
        end
    end

    assign m0 = (d_out_0 != exp0_q[LAT-1]);
    assign m1 = (d_out_1 != exp1_q[LAT-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            flush_q <= '0;
            idx_q   <= '0;
            match_q <= '0;
            err_q   <= '0;
            fidx_q  <= '0;
            fmask_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            idx_q   <= idx_d;
            match_q <= match_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fmask_q <= fmask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        idx_d   = idx_q;
        match_d = match_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fmask_d = fmask_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FLUSH;
                    flush_d = '0;
                    idx_d   = '0;
                    match_d = '0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fmask_d = '0;
                end
            end
            S_FLUSH: begin
                flush_d = flush_q + 4'd1;
                if (flush_q == 4'(LAT - 1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                idx_d = idx_q + 8'd1;
                if (m0 || m1) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    if (err_q == 8'd0) begin
                        fidx_d  = idx_q;
                        fmask_d = {m1, m0};
                    end
                end else if (match_q != 8'hFF) begin
                    match_d = match_q + 8'd1;
                end
                if (idx_q == 8'(N_CHECK - 1)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy           = (state_q == S_FLUSH) || (state_q == S_CHECK);
    assign done           = (state_q == S_DONE);
    assign pass           = (state_q == S_DONE) && (err_q == 8'd0);
    assign match_cnt      = match_q;
    assign err_cnt        = err_q;
    assign first_err_idx  = fidx_q;
    assign first_err_mask = fmask_q;

endmodule

// File: tb/tb_simple_reg_chk.sv
// Bench for simple_reg_chk: two checkers (LAT=1 and LAT=3) watch a modelled register
// whose outputs can be corrupted at chosen samples.
module tb_simple_reg_chk;

    localparam int N  = 10;
    localparam int W0 = 9;
    localparam int W1 = 32;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [W0-1:0] din0;
    logic [W1-1:0] din1;
    logic [W0-1:0] do0 [2];
    logic [W1-1:0] do1 [2];
    logic [1:0]    busy_v, done_v, pass_v;
    logic [7:0]    mc [2];
    logic [7:0]    ec [2];
    logic [7:0]    fi [2];
    logic [1:0]    fm [2];

    logic [W0-1:0] h_in0 [1024];
    logic [W1-1:0] h_in1 [1024];
    logic [W0-1:0] h_o0 [2][1024];
    logic [W1-1:0] h_o1 [2][1024];

    int          e = 0;
    int          cur_ks = -100;
    bit          run_active = 0;
    logic [15:0] cur_l0m, cur_l1m;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  sv_mc [2];
    logic [7:0]  sv_ec [2];
    logic [7:0]  sv_fi [2];
    logic [1:0]  sv_fm [2];

    always #5 clk = ~clk;

    simple_reg_chk #(.W0(W0), .W1(W1), .LAT(1), .N_CHECK(N)) u_chk_l1 (
        .clk(clk), .reset(reset), .start(start),
        .d_in_0(din0), .d_in_1(din1), .d_out_0(do0[0]), .d_out_1(do1[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .match_cnt(mc[0]), .err_cnt(ec[0]),
        .first_err_idx(fi[0]), .first_err_mask(fm[0])
    );

    simple_reg_chk #(.W0(W0), .W1(W1), .LAT(3), .N_CHECK(N)) u_chk_l3 (
        .clk(clk), .reset(reset), .start(start),
        .d_in_0(din0), .d_in_1(din1), .d_out_0(do0[1]), .d_out_1(do1[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .match_cnt(mc[1]), .err_cnt(ec[1]),
        .first_err_idx(fi[1]), .first_err_mask(fm[1])
    );

    function automatic int lat_of(input int x);
        return (x == 0) ? 1 : 3;
    endfunction

    // One clock: random register inputs; register outputs are the input from LAT edges ago,
    // corrupted when the current run asks for it at that sample.
    task automatic tick(input logic st);
        logic [W0-1:0] r0;
        logic [W1-1:0] r1;
        int s, L;
        start = st;
        din0  = W0'($urandom);
        din1  = $urandom;
        h_in0[e] = din0;
        h_in1[e] = din1;
        for (int x = 0; x < 2; x++) begin
            L  = lat_of(x);
            r0 = (e >= L) ? h_in0[e-L] : '0;
            r1 = (e >= L) ? h_in1[e-L] : '0;
            s  = e - cur_ks - L - 1;
            if (run_active && s >= 0 && s < N) begin
                if (cur_l0m[s]) r0 = ~r0;
                if (cur_l1m[s]) r1 = 32'hDEADBEEF;
            end
            do0[x] = r0;
            do1[x] = r1;
            h_o0[x][e] = r0;
            h_o1[x][e] = r1;
        end
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run_check(input logic [15:0] l0m, input logic [15:0] l1m, input bit stray);
        int ks, le, L, t, em, ee, fidx;
        logic [1:0] fmask;
        logic m0, m1, eb, ed;
        cur_l0m = l0m;
        cur_l1m = l1m;
        ks = e;
        cur_ks = e;
        run_active = 1;
        tick(1'b1);
        for (int x = 0; x < 2; x++) begin
            n_checks++;
            if ({mc[x], ec[x], fi[x], fm[x]} !== 26'd0) begin
                $display("FAIL clear_on_flush lat%0d: mc=%0d ec=%0d fi=%0d fm=%b required all 0",
                         lat_of(x), mc[x], ec[x], fi[x], fm[x]);
                n_fail++;
            end
        end
        for (int c = 0; c <= 3 + N + 1; c++) begin
            if (c > 0) tick(stray && c == 6);
            le = e - 1;
            for (int x = 0; x < 2; x++) begin
                L  = lat_of(x);
                eb = (le >= ks) && (le <= ks + L + N - 1);
                ed = (le >= ks + L + N);
                n_checks++;
                if (busy_v[x] !== eb || done_v[x] !== ed) begin
                    $display("FAIL busy_done lat%0d edge+%0d: busy=%b done=%b required busy=%b done=%b",
                             L, le - ks, busy_v[x], done_v[x], eb, ed);
                    n_fail++;
                end
            end
        end
        start = 1'b0;
        run_active = 0;
        for (int x = 0; x < 2; x++) begin
            L = lat_of(x);
            em = 0; ee = 0; fidx = 0; fmask = 2'b00;
            for (int i = 0; i < N; i++) begin
                t  = ks + L + 1 + i;
                m0 = (h_o0[x][t] != h_in0[t-L]);
                m1 = (h_o1[x][t] != h_in1[t-L]);
                if (m0 || m1) begin
                    if (ee == 0) begin
                        fidx  = i;
                        fmask = {m1, m0};
                    end
                    ee++;
                end else begin
                    em++;
                end
            end
            n_checks++;
            if (mc[x] !== 8'(em) || ec[x] !== 8'(ee)) begin
                $display("FAIL counts lat%0d: match=%0d err=%0d required match=%0d err=%0d",
                         L, mc[x], ec[x], em, ee);
                n_fail++;
            end
            n_checks++;
            if (pass_v[x] !== (ee == 0)) begin
                $display("FAIL pass lat%0d: pass=%b required %b", L, pass_v[x], ee == 0);
                n_fail++;
            end
            if (ee != 0) begin
                n_checks++;
                if (fi[x] !== 8'(fidx) || fm[x] !== fmask) begin
                    $display("FAIL first_err lat%0d: idx=%0d mask=%b required idx=%0d mask=%b",
                             L, fi[x], fm[x], fidx, fmask);
                    n_fail++;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1'b1);
            for (int x = 0; x < 2; x++) begin
                n_checks++;
                if ({busy_v[x], done_v[x], pass_v[x], mc[x], ec[x], fi[x], fm[x]} !== 29'd0) begin
                    $display("FAIL reset lat%0d: busy=%b done=%b pass=%b mc=%0d ec=%0d fi=%0d fm=%b required all 0",
                             lat_of(x), busy_v[x], done_v[x], pass_v[x], mc[x], ec[x], fi[x], fm[x]);
                    n_fail++;
                end
            end
        end
        reset = 1'b0;
        tick(1'b0);
        for (int x = 0; x < 2; x++) begin
            n_checks++;
            if (busy_v[x] !== 1'b0) begin
                $display("FAIL reset_start_ignored lat%0d: busy=%b required 0", lat_of(x), busy_v[x]);
                n_fail++;
            end
        end
    endtask

    task automatic test_pass();
        run_check(16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_fault();
        run_check(16'h0000, 16'h0010, 1'b0);
        n_checks++;
        if (ec[0] !== 8'd1 || mc[0] !== 8'd9 || fi[0] !== 8'd4 || fm[0] !== 2'b10) begin
            $display("FAIL fault_lane1: err=%0d match=%0d idx=%0d mask=%b required 1 9 4 10",
                     ec[0], mc[0], fi[0], fm[0]);
            n_fail++;
        end
    endtask

    task automatic test_multi_fault();
        run_check(16'h0084, 16'h0080, 1'b0);
        n_checks++;
        if (ec[0] !== 8'd2 || fi[0] !== 8'd2 || fm[0] !== 2'b01) begin
            $display("FAIL multi_fault: err=%0d idx=%0d mask=%b required 2 2 01", ec[0], fi[0], fm[0]);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        cur_ks = e;
        cur_l0m = 16'h0000;
        cur_l1m = 16'h0000;
        run_active = 1;
        tick(1'b1);
        for (int c = 0; c < 6; c++) tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        run_active = 0;
        for (int x = 0; x < 2; x++) begin
            n_checks++;
            if ({busy_v[x], done_v[x], pass_v[x], mc[x], ec[x], fi[x], fm[x]} !== 29'd0) begin
                $display("FAIL reset_mid lat%0d: busy=%b done=%b mc=%0d ec=%0d required all 0",
                         lat_of(x), busy_v[x], done_v[x], mc[x], ec[x]);
                n_fail++;
            end
        end
        tick(1'b0);
        run_check(16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_check(16'h0208, 16'h0008, 1'b1);
        for (int x = 0; x < 2; x++) begin
            sv_mc[x] = mc[x]; sv_ec[x] = ec[x]; sv_fi[x] = fi[x]; sv_fm[x] = fm[x];
        end
        run_check(16'h0208, 16'h0008, 1'b1);
        for (int x = 0; x < 2; x++) begin
            n_checks++;
            if (mc[x] !== sv_mc[x] || ec[x] !== sv_ec[x] || fi[x] !== sv_fi[x] || fm[x] !== sv_fm[x]) begin
                $display("FAIL repeat_run lat%0d: mc=%0d ec=%0d fi=%0d fm=%b required mc=%0d ec=%0d fi=%0d fm=%b",
                         lat_of(x), mc[x], ec[x], fi[x], fm[x], sv_mc[x], sv_ec[x], sv_fi[x], sv_fm[x]);
                n_fail++;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        for (int x = 0; x < 2; x++) begin
            do0[x] = '0;
            do1[x] = '0;
        end
        cur_l0m = '0;
        cur_l1m = '0;
        #1;
        test_reset();
        test_pass();
        test_fault();
        test_multi_fault();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_reg_chk.md
# simple_reg_chk

Synthesizable response checker for the simple register datapath: the receiving end of the stimulus the register bench drives. It observes the register's inputs (`d_in_0`, `d_in_1`) and outputs (`d_out_0`, `d_out_1`) and predicts each output from the input sampled `LAT` cycles earlier. After `start` it compares a fixed number of samples, counts matches and mismatches, and records the first failure. It sits beside `top_simple_reg_sv` in bench or on-chip self-test and reports pass/fail through level outputs.

## Interface
- `W0`, default 9: lane 0 data width.
- `W1`, default 32: lane 1 data width.
- `LAT`, default 1: register latency in cycles; legal range 1..8.
- `N_CHECK`, default 10: samples compared per run; legal range 1..255.
- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a run; sampled on each rising edge.
- `d_in_0`  in  W0  lane 0 register input (observed).
- `d_in_1`  in  W1  lane 1 register input (observed).
- `d_out_0`  in  W0  lane 0 register output (observed).
- `d_out_1`  in  W1  lane 1 register output (observed).
- `busy`  out  1  high in the FLUSH and CHECK states.
- `done`  out  1  high in the DONE state.
- `pass`  out  1  `done && err_cnt == 0`.
- `match_cnt`  out  8  samples where both lanes matched.
- `err_cnt`  out  8  samples where at least one lane mismatched.
- `first_err_idx`  out  8  sample index (0-based) of the first mismatch; valid only when `err_cnt != 0`.
- `first_err_mask`  out  2  lanes that failed at the first mismatch; bit 0 is lane 0, bit 1 is lane 1.

## Operation
- Expected pipeline: `LAT`-deep shift registers, one per lane. They shift every cycle in every state, including IDLE, with `exp[0] <= d_in_x`. The tail, `exp[LAT-1]`, holds the input sampled `LAT` edges ago.
- FSM states: IDLE, FLUSH, CHECK, DONE.
  - IDLE: go to FLUSH on `start`.
  - FLUSH: wait `LAT` cycles so the pipeline holds only post-start inputs, then go to CHECK.
  - CHECK: compare on each edge, one sample per cycle, for exactly `N_CHECK` cycles, then go to DONE.
  - DONE: hold all results. On `start`, go to FLUSH.
- Entering FLUSH, from IDLE or DONE, clears `match_cnt`, `err_cnt`, `first_err_idx`, `first_err_mask` and the sample index.
- `start` in FLUSH or CHECK is ignored.
- Compare rule: `m0 = (d_out_0 != exp0_tail)`, `m1 = (d_out_1 != exp1_tail)`, using plain `!=`. The bench drives known values, so no X handling is needed.
- If neither lane mismatches, `match_cnt` increments. Otherwise `err_cnt` increments.
- On the first mismatch of a run (`err_cnt == 0` before the update), capture `first_err_idx = sample index` and `first_err_mask = {m1, m0}`. Later mismatches do not overwrite these.
- Counters are 8 bits. With `N_CHECK <= 255` they cannot overflow, but the implementation saturates at 255 anyway.
- Invariant at DONE: `match_cnt + err_cnt == N_CHECK`.
- Reset values: state IDLE; `busy`, `done` and `pass` are 0; all counters and capture registers are 0; pipeline contents are 0.
- Reset in any state, including mid-CHECK, returns the block to IDLE with all outputs at their reset values on the next edge.

## Timing
- `start` sampled high at edge k gives FLUSH during cycles k+1 .. k+LAT.
- Sample 0 is compared at edge k+LAT+1; sample i is compared at edge k+LAT+1+i.
- At each compare edge t, `d_out` sampled at t is checked against `d_in` sampled at t-LAT.
- The last compare is at edge k+LAT+N_CHECK.
- `done` and `pass` go high in the cycle after that edge, and counters are final in the same cycle.
- `busy` is high from cycle k+1 through the last compare cycle.
- Outputs are registered (state-decoded); there is no combinational path from any input to any output.
- `start` and `reset` high on the same edge: `reset` wins.

## Test plan
- Reset: hold `reset` for 3 cycles with `start` high. Required: all outputs 0, state IDLE, `start` ignored.
- Pass run: connect to `top_simple_reg_sv` with `LAT=1`, `N_CHECK=10`, 10 random input pairs, pulse `start`. Required: `busy` for 11 cycles, then `done=1`, `pass=1`, `match_cnt=10`, `err_cnt=0`.
- Injected fault: same as the pass run, but force `d_out_1` to `32'hDEADBEEF` at sample 4 only. Required: `err_cnt=1`, `match_cnt=9`, `first_err_idx=4`, `first_err_mask=2'b10`, `pass=0`.
- Multiple faults: corrupt lane 0 at sample 2 and both lanes at sample 7. Required: `err_cnt=2`, `first_err_idx=2`, `first_err_mask=2'b01`.
- Reset mid-run: assert `reset` at sample 5 of CHECK, then release and `start` again with a clean DUT. Required: outputs 0 after reset; the new run ends with `pass=1`, `match_cnt=10`.
- Restart and ignore: pulse `start` during CHECK, which must have no effect. Then pulse `start` in DONE. Required: counters cleared on FLUSH entry; the second run gives an identical result; with `LAT=3` and a 3-stage DUT, `done` rises 3+10+1 cycles after `start`.
